// File: rtl/shift_rot_pipe.sv
// Pipelined shift/rotate/funnel unit. Every op is normalised at decode to a right
// funnel shift of a 2*WIDTH base, then resolved one shift-amount bit per stage.
`timescale 1ns/1ps
module shift_rot_pipe #(
  parameter int WIDTH = 8,
  parameter int TAGW  = 4,
  localparam int SW   = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       in_op,
  input  logic [SW-1:0]    in_amt,
  input  logic [WIDTH-1:0] in_hi,
  input  logic [WIDTH-1:0] in_data,
  input  logic [TAGW-1:0]  in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAGW-1:0]  out_tag,
  output logic             out_zero,
  output logic             out_err
);

  localparam int BW = 2 * WIDTH;
  localparam logic [SW-1:0] AMT_W    = SW'(WIDTH);
  localparam logic [SW-1:0] AMT_MASK = SW'(WIDTH - 1);

  typedef enum logic [2:0] {
    OP_LSL    = 3'b000,
    OP_LSR    = 3'b001,
    OP_ASR    = 3'b010,
    OP_ROL    = 3'b011,
    OP_ROR    = 3'b100,
    OP_FUNNEL = 3'b101
  } op_e;

  // Handshake: a transfer happens on an edge where valid && ready are both high.
  // The whole pipe moves together on advance; a stalled output freezes every stage,
  // bubbles included. in_ready is dropped during flush so the flush-cycle op is refused.
  logic advance;
  logic accept;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !flush;
  assign accept   = in_valid && in_ready;

  // Decode
  logic [SW-1:0] amt_sat;
  logic [SW-1:0] amt_mod;
  logic [BW-1:0] dec_base_d;
  logic [SW-1:0] dec_s_d;
  logic          dec_err_d;

  always_comb begin
    amt_sat    = (in_amt >= AMT_W) ? AMT_W : in_amt;
    amt_mod    = in_amt & AMT_MASK;
    dec_base_d = {{WIDTH{1'b0}}, in_data};
    dec_s_d    = '0;
    dec_err_d  = 1'b0;
    case (in_op)
      OP_LSL: begin
        dec_base_d = {in_data, {WIDTH{1'b0}}};
        dec_s_d    = AMT_W - amt_sat;
      end
      OP_LSR: begin
        dec_s_d = amt_sat;
      end
      OP_ASR: begin
        dec_base_d = {{WIDTH{in_data[WIDTH-1]}}, in_data};
        dec_s_d    = amt_sat;
      end
      OP_ROL: begin
        dec_base_d = {in_data, in_data};
        dec_s_d    = (AMT_W - amt_mod) & AMT_MASK;
      end
      OP_ROR: begin
        dec_base_d = {in_data, in_data};
        dec_s_d    = amt_mod;
      end
      OP_FUNNEL: begin
        dec_base_d = {in_hi, in_data};
        dec_s_d    = amt_sat;
      end
      default: begin
        dec_err_d = 1'b1;
      end
    endcase
  end

  // Stage 0 is the decode register; stage k+1 holds the base after shift bit k.
  logic              valid_q [SW];
  logic [BW-1:0]     base_q  [SW];
  logic [SW-1:0]     s_q     [SW];
  logic [TAGW-1:0]   tag_q   [SW];
  logic              err_q   [SW];
  logic [BW-1:0]     shifted [SW];

  always_comb begin
    for (int k = 0; k < SW; k++) begin
      shifted[k] = s_q[k][k] ? (base_q[k] >> (1 << k)) : base_q[k];
    end
  end

  // Final stage: outputs are forced to zero for bubbles so idle ports read 0.
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [TAGW-1:0]  out_tag_q,   out_tag_d;
  logic             out_zero_q,  out_zero_d;
  logic             out_err_q,   out_err_d;

  always_comb begin
    out_valid_d = valid_q[SW-1];
    out_data_d  = '0;
    out_tag_d   = '0;
    out_err_d   = 1'b0;
    out_zero_d  = 1'b0;
    if (valid_q[SW-1]) begin
      out_data_d = shifted[SW-1][WIDTH-1:0];
      out_tag_d  = tag_q[SW-1];
      out_err_d  = err_q[SW-1];
      out_zero_d = (out_data_d == '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SW; k++) begin
        valid_q[k] <= 1'b0;
        base_q[k]  <= '0;
        s_q[k]     <= '0;
        tag_q[k]   <= '0;
        err_q[k]   <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (flush) begin
      for (int k = 0; k < SW; k++) begin
        valid_q[k] <= 1'b0;
      end
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_tag_q   <= '0;
      out_zero_q  <= 1'b0;
      out_err_q   <= 1'b0;
    end else if (advance) begin
      valid_q[0] <= accept;
      if (accept) begin
        base_q[0] <= dec_base_d;
        s_q[0]    <= dec_s_d;
        tag_q[0]  <= in_tag;
        err_q[0]  <= dec_err_d;
      end
      for (int k = 1; k < SW; k++) begin
        valid_q[k] <= valid_q[k-1];
        base_q[k]  <= shifted[k-1];
        s_q[k]     <= s_q[k-1];
        tag_q[k]   <= tag_q[k-1];
        err_q[k]   <= err_q[k-1];
      end
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_tag_q   <= out_tag_d;
      out_zero_q  <= out_zero_d;
      out_err_q   <= out_err_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_zero  = out_zero_q;
  assign out_err   = out_err_q;

endmodule

// File: tb/tb_shift_rot_pipe.sv
// Directed and reference-model bench for shift_rot_pipe at WIDTH 4, 8 and 32.
`timescale 1ns/1ps
module tb_shift_rot_pipe;

  localparam int LAT8 = 5;

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_op = '0;
  logic [5:0]  in_amt = '0;
  logic [31:0] in_hi = '0;
  logic [31:0] in_data = '0;
  logic [3:0]  in_tag = '0;
  int          cyc = 0;

  logic        o4_in_ready, o4_out_valid, o4_out_zero, o4_out_err;
  logic [3:0]  o4_out_data, o4_out_tag;
  logic        o8_in_ready, o8_out_valid, o8_out_zero, o8_out_err;
  logic [7:0]  o8_out_data;
  logic [3:0]  o8_out_tag;
  logic        o32_in_ready, o32_out_valid, o32_out_zero, o32_out_err;
  logic [31:0] o32_out_data;
  logic [3:0]  o32_out_tag;

  shift_rot_pipe #(.WIDTH(8), .TAGW(4)) dut8 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o8_in_ready),
    .in_op(in_op), .in_amt(in_amt[3:0]), .in_hi(in_hi[7:0]), .in_data(in_data[7:0]),
    .in_tag(in_tag), .out_valid(o8_out_valid), .out_ready(out_ready), .out_data(o8_out_data),
    .out_tag(o8_out_tag), .out_zero(o8_out_zero), .out_err(o8_out_err));

  shift_rot_pipe #(.WIDTH(4), .TAGW(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o4_in_ready),
    .in_op(in_op), .in_amt(in_amt[2:0]), .in_hi(in_hi[3:0]), .in_data(in_data[3:0]),
    .in_tag(in_tag), .out_valid(o4_out_valid), .out_ready(out_ready), .out_data(o4_out_data),
    .out_tag(o4_out_tag), .out_zero(o4_out_zero), .out_err(o4_out_err));

  shift_rot_pipe #(.WIDTH(32), .TAGW(4)) dut32 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(o32_in_ready),
    .in_op(in_op), .in_amt(in_amt), .in_hi(in_hi), .in_data(in_data),
    .in_tag(in_tag), .out_valid(o32_out_valid), .out_ready(out_ready), .out_data(o32_out_data),
    .out_tag(o32_out_tag), .out_zero(o32_out_zero), .out_err(o32_out_err));

  // Clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: sim time exceeded, got no finish want finish");
    $fatal(1, "watchdog");
  end

  // Independent reference: plain shift/rotate semantics, no base normalisation.
  function automatic logic [31:0] ref_model(input int w, input logic [2:0] op, input int amt,
                                            input logic [31:0] hi, input logic [31:0] d);
    logic [63:0] mask, dd, hh, r;
    int m;
    mask = (64'd1 << w) - 64'd1;
    dd   = {32'd0, d} & mask;
    hh   = {32'd0, hi} & mask;
    m    = amt % w;
    case (op)
      3'd0: r = (amt >= w) ? 64'd0 : (dd << amt);
      3'd1: r = (amt >= w) ? 64'd0 : (dd >> amt);
      3'd2: begin
        if (dd[w-1]) r = (amt >= w) ? mask : ((dd >> amt) | (mask & ~(mask >> amt)));
        else         r = (amt >= w) ? 64'd0 : (dd >> amt);
      end
      3'd3: r = (dd << m) | (dd >> (w - m));
      3'd4: r = (dd >> m) | (dd << (w - m));
      3'd5: r = (amt >= w) ? hh : (((hh << w) | dd) >> amt);
      default: r = dd;
    endcase
    r = r & mask;
    return r[31:0];
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input int amt, input logic [31:0] hi,
                       input logic [31:0] d, input logic [3:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_amt   = 6'(amt);
    in_hi    = hi;
    in_data  = d;
    in_tag   = tag;
  endtask

  task automatic run_one(input logic [2:0] op, input int amt, input logic [31:0] hi,
                         input logic [31:0] d, input logic [3:0] tag,
                         output logic [7:0] rd, output logic rz, output logic re,
                         output logic [3:0] rt, output int lat);
    out_ready = 1'b1;
    drive(op, amt, hi, d, tag);
    tick();
    in_valid = 1'b0;
    lat = 1;
    while (!o8_out_valid && lat < 20) begin
      tick();
      lat++;
    end
    rd = o8_out_data;
    rz = o8_out_zero;
    re = o8_out_err;
    rt = o8_out_tag;
    tick();
  endtask

  // Tests
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++; if (o8_out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", o8_out_valid); end
    total++; if (o8_out_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", o8_out_data); end
    total++; if (o8_out_tag !== 4'h0) begin bad++; $display("FAIL reset_tag: got %h want 0", o8_out_tag); end
    total++; if (o8_out_zero !== 1'b0) begin bad++; $display("FAIL reset_zero: got %b want 0", o8_out_zero); end
    total++; if (o8_out_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", o8_out_err); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (o8_in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready: got %b want 1", o8_in_ready); end
    total++; if (o8_out_valid !== 1'b0) begin bad++; $display("FAIL reset_idle_valid: got %b want 0", o8_out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [2:0] ops [5];
    logic [7:0] exp_v [5];
    ops   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
    exp_v = '{8'hB0, 8'h12, 8'hF2, 8'hB4, 8'hD2};
    out_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c < 5) drive(ops[c], 3, 32'h0, 32'h96, 4'(c + 1));
      else in_valid = 1'b0;
      tick();
      if (c >= 4 && c < 9) begin
        total++; if (o8_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", c - 4, o8_out_valid); end
        total++; if (o8_out_data !== exp_v[c-4]) begin bad++; $display("FAIL b2b_data[%0d]: got %h want %h", c - 4, o8_out_data, exp_v[c-4]); end
        total++; if (o8_out_tag !== 4'(c - 3)) begin bad++; $display("FAIL b2b_tag[%0d]: got %h want %h", c - 4, o8_out_tag, 4'(c - 3)); end
      end else if (c == 3 || c == 9) begin
        total++; if (o8_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle[%0d]: got %b want 0", c, o8_out_valid); end
      end
    end
  endtask

  task automatic test_boundaries();
    logic [2:0] ops [5];
    int         amts [5];
    logic [7:0] dat [5];
    logic [7:0] exp_v [5];
    logic       exp_z [5];
    logic [7:0] rd;
    logic       rz, re;
    logic [3:0] rt;
    int         lat;
    ops   = '{3'd1, 3'd2, 3'd3, 3'd3, 3'd0};
    amts  = '{8, 12, 8, 11, 0};
    dat   = '{8'h96, 8'h80, 8'h96, 8'h96, 8'h01};
    exp_v = '{8'h00, 8'hFF, 8'h96, 8'hB4, 8'h01};
    exp_z = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      run_one(ops[i], amts[i], 32'h0, {24'h0, dat[i]}, 4'(i), rd, rz, re, rt, lat);
      total++; if (rd !== exp_v[i]) begin bad++; $display("FAIL bound_data[%0d]: got %h want %h", i, rd, exp_v[i]); end
      total++; if (rz !== exp_z[i]) begin bad++; $display("FAIL bound_zero[%0d]: got %b want %b", i, rz, exp_z[i]); end
      total++; if (re !== 1'b0) begin bad++; $display("FAIL bound_err[%0d]: got %b want 0", i, re); end
      total++; if (rt !== 4'(i)) begin bad++; $display("FAIL bound_tag[%0d]: got %h want %h", i, rt, 4'(i)); end
      total++; if (lat != LAT8) begin bad++; $display("FAIL bound_lat[%0d]: got %0d want %0d", i, lat, LAT8); end
    end
  endtask

  task automatic test_funnel_illegal();
    logic [2:0] ops [4];
    int         amts [4];
    logic [7:0] his [4];
    logic [7:0] dat [4];
    logic [7:0] exp_v [4];
    logic       exp_e [4];
    logic [7:0] rd;
    logic       rz, re;
    logic [3:0] rt;
    int         lat;
    ops   = '{3'd5, 3'd5, 3'd5, 3'd6};
    amts  = '{4, 8, 0, 0};
    his   = '{8'hA5, 8'hA5, 8'hA5, 8'h00};
    dat   = '{8'h3C, 8'h3C, 8'h3C, 8'h5A};
    exp_v = '{8'h53, 8'hA5, 8'h3C, 8'h5A};
    exp_e = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      run_one(ops[i], amts[i], {24'h0, his[i]}, {24'h0, dat[i]}, 4'(i + 8), rd, rz, re, rt, lat);
      total++; if (rd !== exp_v[i]) begin bad++; $display("FAIL funnel_data[%0d]: got %h want %h", i, rd, exp_v[i]); end
      total++; if (re !== exp_e[i]) begin bad++; $display("FAIL funnel_err[%0d]: got %b want %b", i, re, exp_e[i]); end
      total++; if (rz !== 1'b0) begin bad++; $display("FAIL funnel_zero[%0d]: got %b want 0", i, rz); end
      total++; if (rt !== 4'(i + 8)) begin bad++; $display("FAIL funnel_tag[%0d]: got %h want %h", i, rt, 4'(i + 8)); end
    end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int hold_left = 0;
    bit hold_done = 0;
    logic [7:0] snap;
    out_ready = 1'b1;
    snap = '0;
    for (int c = 0; c < 100 && got < 10; c++) begin
      if (sent < 10) drive(3'd0, 1, 32'h0, 32'(sent + 1), 4'(sent));
      else in_valid = 1'b0;
      if (o8_out_valid && !hold_done && hold_left == 0) begin
        hold_left = 7;
        snap = o8_out_data;
      end
      out_ready = (hold_left == 0);
      #1;
      if (hold_left > 0) begin
        total++; if (o8_in_ready !== 1'b0) begin bad++; $display("FAIL bp_in_ready: got %b want 0", o8_in_ready); end
        total++; if (o8_out_data !== snap) begin bad++; $display("FAIL bp_stable: got %h want %h", o8_out_data, snap); end
        hold_left--;
        if (hold_left == 0) hold_done = 1;
      end else if (o8_out_valid) begin
        total++; if (o8_out_data !== 8'((got + 1) * 2)) begin bad++; $display("FAIL bp_data[%0d]: got %h want %h", got, o8_out_data, 8'((got + 1) * 2)); end
        total++; if (o8_out_tag !== 4'(got)) begin bad++; $display("FAIL bp_tag[%0d]: got %h want %h", got, o8_out_tag, 4'(got)); end
        got++;
      end
      if (in_valid && o8_in_ready) sent++;
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    total++; if (got != 10) begin bad++; $display("FAIL bp_count: got %0d want 10", got); end
    total++; if (hold_done != 1'b1) begin bad++; $display("FAIL bp_hold_seen: got %b want 1", hold_done); end
    for (int i = 0; i < LAT8 + 2; i++) begin
      total++; if (o8_out_valid !== 1'b0) begin bad++; $display("FAIL bp_extra[%0d]: got %b want 0", i, o8_out_valid); end
      tick();
    end
  endtask

  task automatic test_flush();
    logic [7:0] rd;
    logic       rz, re;
    logic [3:0] rt;
    int         lat;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(3'd4, 1, 32'h0, 32'(8'h11 * (i + 1)), 4'(i));
      tick();
    end
    drive(3'd0, 0, 32'h0, 32'h77, 4'hF);
    flush = 1'b1;
    #1;
    total++; if (o8_in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", o8_in_ready); end
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < LAT8 + 3; i++) begin
      total++; if (o8_out_valid !== 1'b0) begin bad++; $display("FAIL flush_leak[%0d]: got %b want 0", i, o8_out_valid); end
      tick();
    end
    run_one(3'd1, 1, 32'h0, 32'h40, 4'h9, rd, rz, re, rt, lat);
    total++; if (rd !== 8'h20) begin bad++; $display("FAIL flush_next_data: got %h want 20", rd); end
    total++; if (rt !== 4'h9) begin bad++; $display("FAIL flush_next_tag: got %h want 9", rt); end
    total++; if (lat != LAT8) begin bad++; $display("FAIL flush_next_lat: got %0d want %0d", lat, LAT8); end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(3'd3, i, 32'h0, 32'hC3, 4'(i));
      tick();
    end
    total++; if (o8_out_valid !== 1'b1) begin bad++; $display("FAIL rst_mid_live: got %b want 1", o8_out_valid); end
    #2;
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    total++; if (o8_out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid: got %b want 0", o8_out_valid); end
    total++; if (o8_out_data !== 8'h00) begin bad++; $display("FAIL rst_mid_data: got %h want 00", o8_out_data); end
    total++; if (o8_out_tag !== 4'h0) begin bad++; $display("FAIL rst_mid_tag: got %h want 0", o8_out_tag); end
    total++; if (o8_out_zero !== 1'b0 || o8_out_err !== 1'b0) begin bad++; $display("FAIL rst_mid_flags: got %b%b want 00", o8_out_zero, o8_out_err); end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (o8_in_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_in_ready: got %b want 1", o8_in_ready); end
    for (int i = 0; i < LAT8 + 3; i++) begin
      total++; if (o8_out_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale[%0d]: got %b want 0", i, o8_out_valid); end
      tick();
    end
  endtask

  task automatic test_param();
    logic [35:0] exp_q4[$], exp_q8[$], exp_q32[$];
    int          cyc_q4[$], cyc_q8[$], cyc_q32[$];
    logic [35:0] e;
    int          ec;
    logic [2:0]  op;
    logic [31:0] hi, d;
    out_ready = 1'b1;
    for (int c = 0; c < 80; c++) begin
      if (c < 64) begin
        op = 3'($urandom_range(0, 5));
        hi = $urandom;
        d  = $urandom;
        drive(op, c, hi, d, 4'(c));
        #1;
        total++; if (!(o4_in_ready && o8_in_ready && o32_in_ready)) begin bad++; $display("FAIL param_ready[%0d]: got %b%b%b want 111", c, o4_in_ready, o8_in_ready, o32_in_ready); end
        exp_q4.push_back({4'(c), ref_model(4, op, c % 8, hi, d)});
        cyc_q4.push_back(cyc + 4);
        exp_q8.push_back({4'(c), ref_model(8, op, c % 16, hi, d)});
        cyc_q8.push_back(cyc + 5);
        exp_q32.push_back({4'(c), ref_model(32, op, c % 64, hi, d)});
        cyc_q32.push_back(cyc + 7);
      end else begin
        in_valid = 1'b0;
        #1;
      end
      tick();
      if (o4_out_valid) begin
        total++;
        if (exp_q4.size() == 0) begin bad++; $display("FAIL param4_extra: got result %h want none", o4_out_data); end
        else begin
          e = exp_q4.pop_front();
          ec = cyc_q4.pop_front();
          if (o4_out_data !== e[3:0] || o4_out_tag !== e[35:32] || o4_out_zero !== (e[3:0] == 4'h0) || o4_out_err !== 1'b0 || cyc != ec) begin
            bad++; $display("FAIL param4: got d=%h t=%h z=%b e=%b cyc=%0d want d=%h t=%h z=%b e=0 cyc=%0d", o4_out_data, o4_out_tag, o4_out_zero, o4_out_err, cyc, e[3:0], e[35:32], e[3:0] == 4'h0, ec);
          end
        end
      end
      if (o8_out_valid) begin
        total++;
        if (exp_q8.size() == 0) begin bad++; $display("FAIL param8_extra: got result %h want none", o8_out_data); end
        else begin
          e = exp_q8.pop_front();
          ec = cyc_q8.pop_front();
          if (o8_out_data !== e[7:0] || o8_out_tag !== e[35:32] || o8_out_zero !== (e[7:0] == 8'h0) || o8_out_err !== 1'b0 || cyc != ec) begin
            bad++; $display("FAIL param8: got d=%h t=%h z=%b e=%b cyc=%0d want d=%h t=%h z=%b e=0 cyc=%0d", o8_out_data, o8_out_tag, o8_out_zero, o8_out_err, cyc, e[7:0], e[35:32], e[7:0] == 8'h0, ec);
          end
        end
      end
      if (o32_out_valid) begin
        total++;
        if (exp_q32.size() == 0) begin bad++; $display("FAIL param32_extra: got result %h want none", o32_out_data); end
        else begin
          e = exp_q32.pop_front();
          ec = cyc_q32.pop_front();
          if (o32_out_data !== e[31:0] || o32_out_tag !== e[35:32] || o32_out_zero !== (e[31:0] == 32'h0) || o32_out_err !== 1'b0 || cyc != ec) begin
            bad++; $display("FAIL param32: got d=%h t=%h z=%b e=%b cyc=%0d want d=%h t=%h z=%b e=0 cyc=%0d", o32_out_data, o32_out_tag, o32_out_zero, o32_out_err, cyc, e[31:0], e[35:32], e[31:0] == 32'h0, ec);
          end
        end
      end
    end
    total++;
    if (exp_q4.size() != 0 || exp_q8.size() != 0 || exp_q32.size() != 0) begin
      bad++; $display("FAIL param_lost: got pending %0d/%0d/%0d want 0/0/0", exp_q4.size(), exp_q8.size(), exp_q32.size());
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_boundaries();
    test_funnel_illegal();
    test_backpressure();
    test_flush();
    test_reset_mid();
    test_param();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
